btn_event_fsm: RTL

Consumer-side companion to the debouncer. It takes the clean, already-synchronized debounced level `db` and turns it into single-cycle command events: press, release, long-press and auto-repeat. These events drive push/pop/select controls of the FIFO front panel. One instance is placed per debounced button, directly downstream of the debouncer.

---
 rtl/btn_event_fsm.sv | 121 ++++++++++++
 1 files changed

// File: rtl/btn_event_fsm.sv
// btn_event_fsm: turns a debounced, clk-synchronous button level into
// single-cycle press / release / long-press / auto-repeat events.
module btn_event_fsm #(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned CW            = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db,
    output logic       press_tick,
    output logic       release_tick,
    output logic       long_tick,
    output logic       repeat_tick,
    output logic       held,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD   = 2'b01,
        ST_REPEAT = 2'b10
    } state_e;

    // Terminal counts: the counter matches on the last cycle of each interval
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = '0;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    // Next-state, counter and tick decode; release takes priority over matches
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (db) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                    press_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (!db) begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = CNT_ZERO;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!db) begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = CNT_ZERO;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_tick   = press_q;
    assign release_tick = release_q;
    assign long_tick    = long_q;
    assign repeat_tick  = repeat_q;
    assign held         = held_q;
    assign state        = state_q;

endmodule
